// File: rtl/debug_pkg.sv
// Shared definitions for the debug observation logic: trace FSM encoding,
// debug word width and a zero-extension helper for narrow debug fields.
package debug_pkg;

  localparam int DBG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_t;

  // Keeps the low 'width' bits of a field and clears the rest of the debug word.
  function automatic logic [DBG_WORD_W-1:0] zext_dbg(input logic [DBG_WORD_W-1:0] value,
                                                      input int unsigned width);
    logic [DBG_WORD_W-1:0] mask;
    mask = (width >= DBG_WORD_W) ? '1 : ((DBG_WORD_W'(1) << width) - DBG_WORD_W'(1));
    return value & mask;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port RAM, DEPTH x WIDTH: synchronous write, registered read.
// No reset on the array or the read register so it maps onto RAM primitives.
module trace_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_trace_buffer.sv
// Circular history of NUM_CH-channel debug samples with arm/trigger/post-trigger
// capture; the history freezes after the trigger and is read back one word per cycle.
module debug_trace_buffer
  import debug_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = ADDR_W + 1,
  localparam int ROW_W    = NUM_CH * DBG_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROW_W-1:0]      ch_data,
  input  logic                  cap_en,
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_age,
  input  logic [CH_W-1:0]       rd_ch,
  output logic [DBG_WORD_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      count,
  output logic [ADDR_W-1:0]     trig_age
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  trace_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
  logic [ADDR_W-1:0] trig_age_reg, trig_age_next;
  logic              wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      post_cnt_reg <= '0;
      trig_age_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      post_cnt_reg <= post_cnt_next;
      trig_age_reg <= trig_age_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    post_cnt_next = post_cnt_reg;
    trig_age_next = trig_age_reg;
    wr_en         = 1'b0;
    // arm overrides everything, including a trigger in the same cycle
    if (arm) begin
      state_next    = ARMED;
      wr_ptr_next   = '0;
      count_next    = '0;
      post_cnt_next = '0;
      trig_age_next = '0;
    end else begin
      case (state_reg)
        ARMED: begin
          if (cap_en) begin
            wr_en = 1'b1;
            if (trig) begin
              if (POST_TRIG == 0) begin
                state_next    = FROZEN;
                trig_age_next = ADDR_W'(POST_TRIG);
              end else begin
                state_next    = POST;
                post_cnt_next = ADDR_W'(POST_TRIG);
              end
            end
          end
        end
        POST: begin
          if (cap_en) begin
            wr_en         = 1'b1;
            post_cnt_next = post_cnt_reg - ADDR_W'(1);
            if (post_cnt_reg == ADDR_W'(1)) begin
              state_next    = FROZEN;
              trig_age_next = ADDR_W'(POST_TRIG);
            end
          end
        end
        default: ;
      endcase
    end
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
      count_next  = (count_reg == FULL) ? count_reg : count_reg + CNT_W'(1);
    end
  end

  // Read side: age 0 is the slot just behind the write pointer.
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              age_ok;
  logic              ch_ok;
  logic              rd_valid_reg;
  logic              rd_zero_reg;
  logic [CH_W-1:0]   rd_ch_reg;
  logic [ROW_W-1:0]  ram_row;
  logic [DBG_WORD_W-1:0] ch_words [NUM_CH];

  assign rd_en   = rd_req && (state_reg == FROZEN) && !arm;
  assign rd_addr = wr_ptr_reg - ADDR_W'(1) - rd_age;
  assign age_ok  = ({1'b0, rd_age} < count_reg);

  generate
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = (rd_ch < CH_W'(NUM_CH));
    end
  endgenerate

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ROW_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_reg),
    .wdata(ch_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(ram_row)
  );

  // rd_zero_reg doubles as the async-reset value of rd_data, since the RAM read register is not reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_zero_reg  <= 1'b1;
      rd_ch_reg    <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        rd_zero_reg <= !(age_ok && ch_ok);
        rd_ch_reg   <= ch_ok ? rd_ch : '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_words
      assign ch_words[gi] = ram_row[gi*DBG_WORD_W +: DBG_WORD_W];
    end
  endgenerate

  assign rd_data  = rd_zero_reg ? '0 : ch_words[rd_ch_reg];
  assign rd_valid = rd_valid_reg;
  assign state    = state_reg;
  assign count    = count_reg;
  assign trig_age = trig_age_reg;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Randomised scoreboard bench for debug_trace_buffer: two builds (4ch/post 2 and
// 3ch/post 0) share the stimulus and are checked against a queue-based history model.
module tb_debug_trace_buffer;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ch_data = '0;
  logic         cap_en = 1'b0, arm = 1'b0, trig = 1'b0, rd_req = 1'b0;
  logic [2:0]   rd_age = '0;
  logic [1:0]   rd_ch = '0;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic [1:0]  a_state, b_state;
  logic [3:0]  a_count, b_count;
  logic [2:0]  a_trig_age, b_trig_age;

  always #5 clk = ~clk;

  debug_trace_buffer #(.NUM_CH(4), .DEPTH(DEPTH), .POST_TRIG(2)) dut_a (
    .clk(clk), .rst(rst), .ch_data(ch_data), .cap_en(cap_en), .arm(arm), .trig(trig),
    .rd_req(rd_req), .rd_age(rd_age), .rd_ch(rd_ch), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .state(a_state), .count(a_count), .trig_age(a_trig_age));

  debug_trace_buffer #(.NUM_CH(3), .DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .ch_data(ch_data[95:0]), .cap_en(cap_en), .arm(arm), .trig(trig),
    .rd_req(rd_req), .rd_age(rd_age), .rd_ch(rd_ch), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .state(b_state), .count(b_count), .trig_age(b_trig_age));

  int checks = 0;
  int errors = 0;

  // Reference model: per build, a state number, post counter and a history queue (newest last).
  int           mst [2];
  int           mpost [2];
  logic [127:0] h0 [$];
  logic [127:0] h1 [$];
  logic [31:0]  e0 [$];
  logic [31:0]  e1 [$];
  logic [31:0]  last_rd [2];

  function automatic int post_trig_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int nch_of(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  task automatic chk(string name, int i, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, i, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0;
      mpost[i] = 0;
      last_rd[i] = '0;
    end
    h0.delete(); h1.delete(); e0.delete(); e1.delete();
  endtask

  task automatic hist_clear(int i);
    if (i == 0) h0.delete(); else h1.delete();
  endtask

  task automatic hist_push(int i, logic [127:0] row);
    if (i == 0) begin
      h0.push_back(row);
      if (h0.size() > DEPTH) void'(h0.pop_front());
    end else begin
      h1.push_back(row);
      if (h1.size() > DEPTH) void'(h1.pop_front());
    end
  endtask

  function automatic int hist_size(int i);
    return (i == 0) ? h0.size() : h1.size();
  endfunction

  function automatic logic [31:0] exp_read(int i, int age, int ch);
    logic [127:0] row;
    int sz;
    sz = hist_size(i);
    if (age >= sz || ch >= nch_of(i)) return 32'h0;
    if (i == 0) row = h0[sz-1-age];
    else        row = h1[sz-1-age];
    return row[ch*32 +: 32];
  endfunction

  task automatic model_step(int i);
    logic [31:0] v;
    if (arm) begin
      mst[i] = 1;
      mpost[i] = 0;
      hist_clear(i);
    end else begin
      case (mst[i])
        1: if (cap_en) begin
          hist_push(i, ch_data);
          if (trig) begin
            if (post_trig_of(i) == 0) mst[i] = 3;
            else begin
              mst[i] = 2;
              mpost[i] = post_trig_of(i);
            end
          end
        end
        2: if (cap_en) begin
          hist_push(i, ch_data);
          mpost[i]--;
          if (mpost[i] == 0) mst[i] = 3;
        end
        3: if (rd_req) begin
          v = exp_read(i, int'(rd_age), int'(rd_ch));
          if (i == 0) e0.push_back(v); else e1.push_back(v);
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_dut(int i, logic [1:0] st, logic [3:0] cnt, logic [2:0] ta,
                           logic rv, logic [31:0] rd);
    int qs;
    logic [31:0] ev;
    qs = (i == 0) ? e0.size() : e1.size();
    chk("state", i, st, mst[i]);
    chk("count", i, cnt, hist_size(i));
    if (mst[i] == 3) chk("trig_age", i, ta, post_trig_of(i));
    chk("rd_valid", i, rv, (qs > 0) ? 1 : 0);
    if (rv && qs > 0) begin
      if (i == 0) ev = e0.pop_front(); else ev = e1.pop_front();
      chk("rd_data", i, rd, ev);
      last_rd[i] = ev;
    end else if (!rv) begin
      chk("rd_hold", i, rd, last_rd[i]);
      if (i == 0) e0.delete(); else e1.delete();
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, a_state, a_count, a_trig_age, a_rd_valid, a_rd_data);
    check_dut(1, b_state, b_count, b_trig_age, b_rd_valid, b_rd_data);
  end

  task automatic drive(bit ce, bit a, bit t, bit r, int age, int ch, logic [31:0] d0);
    cap_en  = ce;
    arm     = a;
    trig    = t;
    rd_req  = r;
    rd_age  = 3'(age);
    rd_ch   = 2'(ch);
    ch_data = {$urandom, $urandom, $urandom, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("reset_trig_age", 0, a_trig_age, 0);
    idle(2);

    // Basic capture: ch0 = 1..5, trigger on 5, two post samples
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) drive(1, 0, k == 5, 0, 0, 0, 32'(k));
    chk("basic_state", 0, a_state, 3);
    chk("basic_count", 0, a_count, 7);
    chk("basic_count", 1, b_count, 5);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, k, 0, 0);
    drive(0, 0, 0, 1, 7, 0, 0);
    drive(0, 0, 0, 1, 0, 3, 0);
    idle(2);

    // Short history: count=3 in the post-trigger build, old age reads zero
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) drive(1, 0, k == 1, 0, 0, 0, 32'(k));
    chk("short_count", 0, a_count, 3);
    drive(0, 0, 0, 1, 7, 0, 0);
    drive(0, 0, 0, 1, 2, 1, 0);
    idle(2);

    // Wrap: 22 samples, trigger at 20
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 22; k++) drive(1, 0, k == 20, 0, 0, 0, 32'(k));
    chk("wrap_count", 0, a_count, 8);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 7, 0, 0);
    drive(0, 0, 0, 1, 3, 2, 0);
    idle(2);

    // Stalls: capture every other cycle, trigger on a stall cycle, reads while armed
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) drive(c % 2 == 1, 0, c == 4, 1, c % 8, 0, 32'(100 + c));
    chk("stall_trig_ignored", 0, a_state, 1);
    chk("stall_trig_ignored", 1, b_state, 1);
    for (int c = 0; c < 3; c++) drive(1, 0, c == 0, 0, 0, 0, 32'(200 + c));
    for (int k = 0; k < 6; k++) drive(0, 0, 0, 1, k, 0, 0);
    idle(2);

    // Re-arm during POST with a coincident trigger and read
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 32'h55);
    chk("post_state", 0, a_state, 2);
    drive(1, 1, 1, 1, 0, 0, 32'h66);
    chk("rearm_state", 0, a_state, 1);
    chk("rearm_count", 0, a_count, 0);
    chk("rearm_state", 1, b_state, 1);
    chk("rearm_count", 1, b_count, 0);

    // Reset while frozen with a read in flight, inputs still active
    for (int k = 1; k <= 4; k++) drive(1, 0, k == 2, 0, 0, 0, 32'(k));
    drive(1, 0, 1, 1, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_reset_state", 0, a_state, 0);
    chk("async_reset_valid", 0, a_rd_valid, 0);
    drive(1, 0, 1, 1, 0, 0, 32'h77);
    drive(1, 0, 1, 1, 0, 0, 32'h78);
    rst = 1'b0;
    drive(1, 0, 1, 1, 0, 0, 32'h79);
    chk("idle_no_capture", 0, a_count, 0);

    // Randomised traffic
    for (int n = 0; n < 2500; n++) begin
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 60,
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Parametrised successor to the pipeline debug snapshot port.
- Instead of holding only the last cycle of debug words, it keeps a circular history of DEPTH samples of NUM_CH 32-bit channels.
- Supports arm/trigger/post-trigger capture, then freezes the history for host or bench readout through a registered read port.
- Sits beside the pipeline top, fed by the same zero-extended debug words.

Parameters:
NUM_CH, 32, number of 32-bit debug channels per sample (1..64)
DEPTH, 16, history depth in samples; power of two, 2..256
POST_TRIG, 4, samples captured after the trigger sample before freezing (0..DEPTH-1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ch_data  in  NUM_CH*32  flat channel bus; channel k at bits [32k+31:32k]
cap_en  in  1  sample qualifier; low for pipeline stall cycles, which are not recorded
arm  in  1  one-cycle pulse: clear history and start capturing
trig  in  1  trigger event, sampled only in ARMED with cap_en=1
rd_req  in  1  read request, honoured only in FROZEN
rd_age  in  $clog2(DEPTH)  sample age to read: 0 = newest (last captured), up to count-1
rd_ch  in  $clog2(NUM_CH) (min 1)  channel select
rd_data  out  32  read data
rd_valid  out  1  one-cycle pulse, rd_data valid
state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
count  out  $clog2(DEPTH)+1  valid samples held, saturating at DEPTH
trig_age  out  $clog2(DEPTH)  age of the trigger sample in the frozen history (= POST_TRIG)

Behaviour:
- Reset (async): state=IDLE, wr_ptr=0, count=0, post_cnt=0, rd_data=0, rd_valid=0, trig_age=0. The memory array is not reset.
- IDLE: no capture.
  - arm -> ARMED; wr_ptr=0, count=0.
- ARMED: each cycle with cap_en=1:
  - write ch_data at wr_ptr;
  - wr_ptr += 1 mod DEPTH (wrap-around overwrites the oldest sample);
  - count = min(count+1, DEPTH).
- Trigger in ARMED (trig=1, cap_en=1): the trigger-cycle sample is written.
  - If POST_TRIG=0 -> FROZEN the next cycle.
  - Otherwise -> POST with post_cnt=POST_TRIG.
  - trig while cap_en=0 is ignored.
- POST: each cap_en=1 cycle writes a sample and decrements post_cnt. The write that takes post_cnt to 0 moves to FROZEN. trig is ignored.
- FROZEN: no writes. trig_age=POST_TRIG.
  - rd_req -> at the next edge, rd_data = mem[(wr_ptr-1-rd_age) mod DEPTH][rd_ch], rd_valid=1 for one cycle. Latency is 1 cycle.
  - Back-to-back rd_req are allowed, one result per cycle.
  - rd_age >= count returns 0 with rd_valid=1.
  - rd_ch >= NUM_CH returns 0.
- rd_req outside FROZEN: no response (rd_valid stays 0).
- arm in any state restarts: state=ARMED, count=0, wr_ptr=0, post_cnt=0. A read issued in the same cycle is dropped.
- arm and trig in the same cycle: arm wins; trig is ignored that cycle.
- count/wr_ptr arithmetic is modulo DEPTH on the pointer only; count never exceeds DEPTH.
- rd_data holds its last value when rd_valid=0.
- Reset mid-POST or mid-read returns to IDLE immediately. Outputs take their reset values asynchronously.
- Memory is one write port (full-row write) and one registered read port; it is inferable as a distributed/block RAM of DEPTH x NUM_CH*32.

Decomposition:
- Shared package debug_pkg: trace_state_t enum (IDLE, ARMED, POST, FROZEN), DBG_WORD_W=32, and a helper function for zero-extending narrow fields to 32 bits. The same helper replaces the per-field alignment instances in the existing debug port.
- One natural sub-module: trace_ram. It is a parametrised DEPTH x WIDTH simple dual-port RAM (sync write, registered read).
- FSM, pointer and count logic live in the top.

Test Plan:
- Reset/idle: assert rst mid-run, drive cap_en=1, trig=1 -> state=0, count=0, rd_valid never asserts.
- Basic capture: NUM_CH=4, DEPTH=8, POST_TRIG=2. arm, then 5 samples with ch0=1..5; trig on sample 5; 2 more samples (6,7) -> FROZEN, count=7. Reading age 2 ch0 -> 5 (trigger); age 0 -> 7.
- Wrap: as above but 20 samples 1..20 before trig at 20, then 21, 22 -> count=8. age 0 -> 22, age 7 -> 15.
- Stalls: cap_en=0 on alternate cycles with ch0 counting every cycle; trig during a cap_en=0 cycle -> ignored, no state change. Recorded values are only those from cap_en=1 cycles.
- Readout: in FROZEN, rd_req for 3 consecutive cycles (ages 0,1,2) -> 3 consecutive rd_valid pulses, 1-cycle latency, correct data. rd_age=7 with count=3 -> rd_data=0. rd_req in ARMED -> no rd_valid.
- Re-arm: arm while in POST and with trig in the same cycle -> state=ARMED, count=0. POST_TRIG=0 build: trig -> FROZEN next cycle, age 0 = trigger sample.
